alu_exec_stage: RTL and testbench

//  Two-stage pipelined execute stage for KGP-RISC. Accepts decoded ALU operations from issue over

---
 rtl/alu_exec_stage.sv | 194 +++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Two-stage pipelined KGP-RISC execute stage: S1 holds the accepted op, S2 holds the computed
// result and flags. Elastic valid/ready on both sides, plus the architectural z/s/c flag register.
module alu_exec_stage #(
    parameter int W     = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_upd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             out_z,
    output logic             out_s,
    output logic             out_c,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_c
);
    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NEG  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1110;
    localparam logic [3:0] OP_SRA  = 4'b1111;
    localparam logic [3:0] OP_SLLV = 4'b1000;
    localparam logic [3:0] OP_SRLV = 4'b1010;
    localparam logic [3:0] OP_SRAV = 4'b1011;

    logic             s1_v_reg;
    logic [3:0]       s1_op_reg;
    logic [W-1:0]     s1_a_reg;
    logic [W-1:0]     s1_b_reg;
    logic [4:0]       s1_shamt_reg;
    logic [TAG_W-1:0] s1_tag_reg;
    logic             s1_upd_reg;

    logic             s2_v_reg;
    logic [W-1:0]     s2_result_reg;
    logic [TAG_W-1:0] s2_tag_reg;
    logic             s2_err_reg;
    logic             s2_z_reg;
    logic             s2_s_reg;
    logic             s2_c_reg;
    logic             s2_upd_reg;

    logic             flag_z_reg;
    logic             flag_s_reg;
    logic             flag_c_reg;

    logic             adv1;
    logic             adv2;
    logic             accept;
    logic             retire;

    logic [W-1:0]     result_next;
    logic             err_next;
    logic             z_next;
    logic             s_next;
    logic             c_next;
    logic [W:0]       sum_wide;
    logic [W:0]       neg_wide;
    logic [4:0]       sh_b;

    assign adv2     = !s2_v_reg || out_ready;
    assign adv1     = !s1_v_reg || adv2;
    assign in_ready = adv1;
    // Flush wins over acceptance: a handshake in the flush cycle is consumed but discarded.
    assign accept   = in_valid && adv1 && !flush;
    assign retire   = s2_v_reg && out_ready && s2_upd_reg && !s2_err_reg;

    assign sum_wide = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
    assign neg_wide = {1'b0, ~s1_b_reg} + {{W{1'b0}}, 1'b1};
    assign sh_b     = s1_b_reg[4:0];

    always_comb begin
        result_next = '0;
        err_next    = 1'b0;
        c_next      = 1'b0;
        case (s1_op_reg)
            OP_MOV:  result_next = s1_a_reg;
            OP_ADD:  begin
                result_next = sum_wide[W-1:0];
                c_next      = sum_wide[W];
            end
            OP_AND:  result_next = s1_a_reg & s1_b_reg;
            OP_XOR:  result_next = s1_a_reg ^ s1_b_reg;
            OP_NEG:  begin
                result_next = neg_wide[W-1:0];
                c_next      = neg_wide[W];
            end
            OP_SLL:  result_next = s1_a_reg << s1_shamt_reg;
            OP_SRL:  result_next = s1_a_reg >> s1_shamt_reg;
            OP_SRA:  result_next = $signed(s1_a_reg) >>> s1_shamt_reg;
            OP_SLLV: result_next = s1_a_reg << sh_b;
            OP_SRLV: result_next = s1_a_reg >> sh_b;
            OP_SRAV: result_next = $signed(s1_a_reg) >>> sh_b;
            default: err_next = 1'b1;
        endcase
        z_next = !err_next && (result_next == '0);
        s_next = result_next[W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg     <= 1'b0;
            s1_op_reg    <= '0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_shamt_reg <= '0;
            s1_tag_reg   <= '0;
            s1_upd_reg   <= 1'b0;
        end else begin
            if (flush) begin
                s1_v_reg <= 1'b0;
            end else if (adv1) begin
                s1_v_reg <= in_valid;
            end
            if (accept) begin
                s1_op_reg    <= in_op;
                s1_a_reg     <= in_a;
                s1_b_reg     <= in_b;
                s1_shamt_reg <= in_shamt;
                s1_tag_reg   <= in_tag;
                s1_upd_reg   <= in_upd;
            end
        end
    end

    // S2 data only moves when its slot frees up, so out_* hold steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg      <= 1'b0;
            s2_result_reg <= '0;
            s2_tag_reg    <= '0;
            s2_err_reg    <= 1'b0;
            s2_z_reg      <= 1'b0;
            s2_s_reg      <= 1'b0;
            s2_c_reg      <= 1'b0;
            s2_upd_reg    <= 1'b0;
        end else begin
            if (flush) begin
                s2_v_reg <= 1'b0;
            end else if (adv2) begin
                s2_v_reg <= s1_v_reg;
            end
            if (adv2 && s1_v_reg && !flush) begin
                s2_result_reg <= result_next;
                s2_tag_reg    <= s1_tag_reg;
                s2_err_reg    <= err_next;
                s2_z_reg      <= z_next;
                s2_s_reg      <= s_next;
                s2_c_reg      <= c_next;
                s2_upd_reg    <= s1_upd_reg;
            end
        end
    end

    // A result retiring in a flush cycle still commits its flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_reg <= 1'b0;
            flag_s_reg <= 1'b0;
            flag_c_reg <= 1'b0;
        end else if (retire) begin
            flag_z_reg <= s2_z_reg;
            flag_s_reg <= s2_s_reg;
            flag_c_reg <= s2_c_reg;
        end
    end

    assign out_valid  = s2_v_reg;
    assign out_result = s2_result_reg;
    assign out_tag    = s2_tag_reg;
    assign out_err    = s2_err_reg;
    assign out_z      = s2_z_reg;
    assign out_s      = s2_s_reg;
    assign out_c      = s2_c_reg;
    assign flag_z     = flag_z_reg;
    assign flag_s     = flag_s_reg;
    assign flag_c     = flag_c_reg;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios followed by randomized traffic, all checked
// against an in-order queue model of the pipeline plus an arithmetic model of each opcode.
module tb_alu_exec_stage;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_shamt;
    logic [4:0]  in_tag;
    logic        in_upd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_err;
    logic        out_z;
    logic        out_s;
    logic        out_c;
    logic        flag_z;
    logic        flag_s;
    logic        flag_c;

    alu_exec_stage #(.W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_shamt(in_shamt), .in_tag(in_tag), .in_upd(in_upd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .out_err(out_err), .out_z(out_z), .out_s(out_s), .out_c(out_c),
        .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        err;
        logic        z;
        logic        s;
        logic        c;
        logic        upd;
        logic        rdy;
    } exp_t;

    exp_t     q[$];
    logic [2:0] flags_exp;
    int       checks = 0;
    int       errors = 0;
    bit       accepted;
    bit       rnd_mode = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] sh,
                                       input logic [4:0] tg, input logic up);
        exp_t e;
        longint unsigned sum;
        e.res = 32'd0; e.err = 1'b0; e.c = 1'b0; e.tag = tg; e.upd = up; e.rdy = 1'b0;
        case (op)
            4'd0:  e.res = a;
            4'd1:  begin
                sum   = longint'(a) + longint'(b);
                e.res = sum[31:0];
                e.c   = (sum > 64'h0000_0000_FFFF_FFFF);
            end
            4'd2:  e.res = a & b;
            4'd3:  e.res = a ^ b;
            4'd5:  begin
                e.res = 32'd0 - b;
                e.c   = (b == 32'd0);
            end
            4'd12: e.res = a << sh;
            4'd14: e.res = a >> sh;
            4'd15: e.res = $signed(a) >>> sh;
            4'd8:  e.res = a << b[4:0];
            4'd10: e.res = a >> b[4:0];
            4'd11: e.res = $signed(a) >>> b[4:0];
            default: e.err = 1'b1;
        endcase
        e.z = !e.err && (e.res == 32'd0);
        e.s = e.res[31];
        return e;
    endfunction

    // One clock: check everything visible now, then advance the model across the edge.
    task automatic cycle();
        bit   exp_rdy;
        bit   exp_ov;
        bit   fire;
        bit   ofire;
        exp_t f;
        if (rnd_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
        end
        #1;
        exp_rdy = (q.size() < 2) || out_ready;
        exp_ov  = (q.size() > 0) && q[0].rdy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            f = q[0];
            chk("out_result", out_result, f.res);
            chk("out_tag", {27'd0, out_tag}, {27'd0, f.tag});
            chk("out_err", {31'd0, out_err}, {31'd0, f.err});
            chk("out_zsc", {29'd0, out_z, out_s, out_c}, {29'd0, f.z, f.s, f.c});
        end
        chk("flags", {29'd0, flag_z, flag_s, flag_c}, {29'd0, flags_exp});
        fire     = in_valid && exp_rdy;
        ofire    = exp_ov && out_ready;
        accepted = fire;
        @(posedge clk);
        if (ofire) begin
            if (q[0].upd && !q[0].err) flags_exp = {q[0].z, q[0].s, q[0].c};
            void'(q.pop_front());
        end
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0) begin
                f = q[0];
                f.rdy = 1'b1;
                q[0] = f;
            end
            if (fire) q.push_back(ref_model(in_op, in_a, in_b, in_shamt, in_tag, in_upd));
        end
        @(negedge clk);
        $display("cyc in_v=%0b in_rdy=%0b out_v=%0b out_rdy=%0b res=%h tag=%0d flags=%b q=%0d",
                 in_valid, in_ready, out_valid, out_ready, out_result, out_tag,
                 {flag_z, flag_s, flag_c}, q.size());
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] tg, input logic up);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_shamt = sh; in_tag = tg; in_upd = up;
        accepted = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (accepted) break;
        end
        chk("accept_timeout", {31'd0, accepted}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            cycle();
        end
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] specials [4];
        logic [31:0] ra;
        logic [31:0] rb;
        specials[0] = 32'h0; specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000; specials[3] = 32'h1;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_a = '0; in_b = '0; in_shamt = '0; in_tag = '0; in_upd = 1'b0;
        flags_exp = 3'b000;

        // Reset state
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_err_zsc", {27'd0, out_tag, out_err, out_z, out_s, out_c}, 32'd0);
        chk("rst_flags", {29'd0, flag_z, flag_s, flag_c}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 1: single add, two-cycle latency
        issue(4'b0001, 32'd12, 32'd10, 5'd0, 5'd1, 1'b0);
        drain();

        // 2: back-to-back ops
        issue(4'b0000, 32'd12, 32'd0, 5'd0, 5'd2, 1'b0);
        issue(4'b0101, 32'd0, 32'd10, 5'd0, 5'd3, 1'b0);
        issue(4'b0011, 32'd8, 32'd8, 5'd0, 5'd4, 1'b0);
        issue(4'b0010, 32'd8, 32'd8, 5'd0, 5'd5, 1'b0);
        drain();

        // 3: shifts
        issue(4'b1100, 32'd4, 32'd0, 5'd2, 5'd6, 1'b0);
        issue(4'b1110, 32'd8, 32'd0, 5'd2, 5'd7, 1'b0);
        issue(4'b1000, 32'd4, 32'd2, 5'd0, 5'd8, 1'b0);
        issue(4'b1010, 32'h8000_0000, 32'd2, 5'd0, 5'd9, 1'b0);
        issue(4'b1011, 32'h8000_0000, 32'd2, 5'd0, 5'd10, 1'b0);
        issue(4'b1111, 32'd8, 32'd0, 5'd2, 5'd11, 1'b0);
        issue(4'b1100, 32'h1234_5678, 32'd0, 5'd0, 5'd12, 1'b0);
        drain();

        // 4: wrapping add latches flags, illegal op leaves them
        issue(4'b0001, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd13, 1'b1);
        drain();
        cycle();
        chk("wrap_flags", {29'd0, flag_z, flag_s, flag_c}, 32'd5);
        issue(4'b0100, 32'd3, 32'd3, 5'd0, 5'd14, 1'b1);
        drain();
        cycle();
        chk("illegal_flags", {29'd0, flag_z, flag_s, flag_c}, 32'd5);

        // 5: backpressure with three ops offered
        out_ready = 1'b0;
        issue(4'b0001, 32'd1, 32'd2, 5'd0, 5'd15, 1'b0);
        issue(4'b0001, 32'd3, 32'd4, 5'd0, 5'd16, 1'b0);
        in_valid = 1'b1; in_op = 4'b0000; in_a = 32'd77; in_tag = 5'd17; in_upd = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("stall_third_blocked", {31'd0, accepted}, 32'd0);
        out_ready = 1'b1;
        issue(4'b0000, 32'd77, 32'd0, 5'd0, 5'd17, 1'b0);
        drain();

        // 6: flush with two in flight; the retiring head still commits flags
        out_ready = 1'b0;
        issue(4'b0001, 32'd5, 32'd5, 5'd0, 5'd18, 1'b1);
        issue(4'b0001, 32'd6, 32'd6, 5'd0, 5'd19, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_op = 4'b0000; in_a = 32'd99; in_tag = 5'd20; in_upd = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        chk("flush_flags", {29'd0, flag_z, flag_s, flag_c}, 32'd0);
        cycle();

        // 6b: asynchronous reset in the middle of a stall
        issue(4'b0001, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd21, 1'b1);
        drain();
        cycle();
        out_ready = 1'b0;
        issue(4'b0001, 32'd1, 32'd1, 5'd0, 5'd22, 1'b0);
        issue(4'b0001, 32'd2, 32'd2, 5'd0, 5'd23, 1'b0);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_flags", {29'd0, flag_z, flag_s, flag_c}, 32'd0);
        chk("arst_out_result", out_result, 32'd0);
        q.delete();
        flags_exp = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();

        // Randomized traffic with random backpressure and flushes
        rnd_mode = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                cycle();
            end else begin
                ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
                rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
                issue(4'($urandom_range(0, 15)), ra, rb, 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
        end
        rnd_mode = 0;
        drain();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
